// File: rtl/instrmem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instrmem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10
  } state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instrmem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// The array is never reset.
module instrmem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instrmem_loader.sv
// Streams a program into the instruction RAM, then serves CPU fetches that are
// qualified against the number of words written by the most recent load.
module instrmem_loader
  import instrmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  output logic [31:0]      instr,
  output logic             fetch_fault,
  output logic             cpu_stall,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic [CNT_W-1:0] words_loaded
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             fetch_ok;
  logic [31:0]      rd_data;

  instrmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (cnt_q[AW-1:0]),
    .wdata (load_data),
    .raddr (addr[AW+1:2]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The count never exceeds DEPTH: the word written at DEPTH-1 forces RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (load_last || (cnt_q == CNT_W'(DEPTH - 1))) begin
        state_d = RUN;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Reset gates the outputs immediately so nothing leaks while it is held.
  always_comb begin
    load_ready = 1'b0;
    cpu_stall  = 1'b1;
    fetch_ok   = 1'b0;
    case (state_q)
      EMPTY: begin
        load_ready = 1'b0;
        cpu_stall  = 1'b1;
      end
      LOAD: begin
        load_ready = !load_start && !reset;
        cpu_stall  = 1'b1;
      end
      RUN: begin
        cpu_stall = reset;
        fetch_ok  = !reset && (addr[1:0] == 2'b00) && (addr[31:2] < 30'(cnt_q));
      end
      default: begin
        load_ready = 1'b0;
        cpu_stall  = 1'b1;
        fetch_ok   = 1'b0;
      end
    endcase
  end

  assign accept       = load_valid && load_ready;
  assign instr        = fetch_ok ? rd_data : INSTR_NOP;
  assign fetch_fault  = !fetch_ok;
  assign words_loaded = cnt_q;

endmodule

// File: doc/instrmem_loader.md
INSTRMEM_LOADER -- requirements
Module: instrmem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction storage size in 32-bit words; power of two, 4..4096.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1: width of the loaded-word counter.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port addr, input, 32: CPU fetch byte address.
REQ-006 Port instr, output, 32: fetched instruction, combinational from addr and stored state.
REQ-007 Port fetch_fault, output, 1: current addr is misaligned, out of loaded range, or memory not in RUN.
REQ-008 Port cpu_stall, output, 1: high whenever state is not RUN.
REQ-009 Port load_start, input, 1: one-cycle request to (re)start program loading.
REQ-010 Port load_valid, input, 1: load_data holds a valid instruction word.
REQ-011 Port load_data, input, 32: instruction word being loaded.
REQ-012 Port load_last, input, 1: qualifies the current word as the final word of the program.
REQ-013 Port load_ready, output, 1: loader accepts a word this cycle.
REQ-014 Port words_loaded, output, CNT_W: number of words written since the last load_start.

Function
REQ-015 The FSM SHALL have three states: EMPTY, LOAD and RUN.
REQ-016 In EMPTY: load_ready=0, cpu_stall=1, instr=0, fetch_fault=1.
REQ-017 load_start in any state SHALL move to LOAD next cycle and set words_loaded=0; nothing is written that cycle.
REQ-018 load_ready SHALL be 1 only in LOAD and only when load_start=0.
REQ-019 A word is accepted when load_valid and load_ready are both 1; it is written to mem[words_loaded], and words_loaded increments by 1.
REQ-020 An accepted word with load_last=1 SHALL move the FSM to RUN next cycle.
REQ-021 An accepted word written at index DEPTH-1 SHALL move the FSM to RUN next cycle, regardless of load_last.
REQ-022 Once words_loaded=DEPTH, no further writes SHALL occur until the next load_start; there is no wrap-around.
REQ-023 In RUN, load_valid SHALL be ignored.
REQ-024 In RUN, instr SHALL equal mem[addr[31:2]] when addr[1:0]==0 and addr[31:2]<words_loaded.
REQ-025 In RUN, when either condition of REQ-024 fails, instr SHALL be 0 (NOP) and fetch_fault=1.
REQ-026 In LOAD, instr SHALL be 0 and fetch_fault=1.
REQ-027 fetch_fault SHALL be 0 only in the valid-fetch case of REQ-024.
REQ-028 Words beyond words_loaded SHALL never be visible on instr, even if they hold data from an earlier load.
REQ-029 cpu_stall SHALL drop to 0 in the first cycle the state is RUN.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=EMPTY and words_loaded=0; it overrides load_start.
REQ-031 During and after reset: instr=0, fetch_fault=1, cpu_stall=1, load_ready=0.
REQ-032 Memory array contents SHALL NOT be cleared by reset; they are unreachable until reloaded (REQ-028).
REQ-033 Reset asserted mid-LOAD SHALL abandon the load; the word presented in that cycle is not written.

Structure
REQ-034 A shared package instrmem_pkg SHALL hold the state enum (EMPTY/LOAD/RUN) and the constant INSTR_NOP = 32'h0000_0000.
REQ-035 Storage SHALL be a sub-module instrmem_ram: parameter DEPTH, one synchronous write port, one asynchronous read port, no reset.
REQ-036 The FSM, counter and fetch-qualification logic SHALL live in instrmem_loader.

Verification
REQ-037 Reset, then addr=0 -> instr=0, fetch_fault=1, cpu_stall=1, load_ready=0.
REQ-038 load_start, then stream 0x20100011 and 0xAC10F000 (last on the second word), then addr=0/4/8 -> 0x20100011 / 0xAC10F000 / 0 with fault=1; words_loaded=2, cpu_stall=0.
REQ-039 In RUN, addr=0x2 -> instr=0, fetch_fault=1.
REQ-040 DEPTH=4, stream 6 words with load_last never set -> RUN after the 4th word, words_loaded=4, words 5-6 not accepted (load_ready=0).
REQ-041 Load 3 words, then load_start, reload 1 word -> addr=4 returns 0 with fault=1, not the old data.
REQ-042 reset asserted after the 2nd of 4 words -> EMPTY, words_loaded=0; load_start on the same cycle as reset -> state remains EMPTY.
